// File: rtl/button_pkg.sv
// Shared encodings for the debounced button bank.
// Toggle FSM states and per-channel mode values.
package button_pkg;

  typedef enum logic [1:0] {
    OFF_IDLE = 2'b00,
    ON_HELD  = 2'b01,
    ON_IDLE  = 2'b11,
    OFF_HELD = 2'b10
  } tgl_state_t;

  localparam logic MODE_TOGGLE    = 1'b0;
  localparam logic MODE_MOMENTARY = 1'b1;

endpackage

// File: rtl/button_debounce.sv
// One channel: 2-flop synchroniser and stable-sample debounce counter.
// Accept strobes and deb_next are combinational for the current edge.
module button_debounce
  import button_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CNT_W = 3
) (
  input  logic clk,
  input  logic rst_n,
  input  logic button,
  output logic deb_next,
  output logic accept_rise,
  output logic accept_fall
);

  localparam logic [CNT_W-1:0] CNT_MAX =
    CNT_W'(DEBOUNCE_CYCLES - 1);

  logic s1;
  logic s2;
  logic deb;
  logic accept;
  logic [CNT_W-1:0] cnt;

  assign accept = (s2 != deb) && (cnt == CNT_MAX);
  assign deb_next = accept ? s2 : deb;
  assign accept_rise = accept & s2;
  assign accept_fall = accept & ~s2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1  <= 1'b0;
      s2  <= 1'b0;
      deb <= 1'b0;
      cnt <= '0;
    end else begin
      s1 <= button;
      s2 <= s1;
      if (s2 == deb) begin
        cnt <= '0;
      end else if (accept) begin
        deb <= s2;
        cnt <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/button_toggle_bank.sv
// Multi-channel debounced buttons with toggle/momentary outputs.
// Emits one-cycle press/release pulses per channel.
module button_toggle_bank
  import button_pkg::*;
#(
  parameter int N_CH = 4,
  parameter int DEBOUNCE_CYCLES = 4,
  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N_CH-1:0] button,
  input  logic [N_CH-1:0] mode,
  input  logic            clear,
  output logic [N_CH-1:0] state_out,
  output logic [N_CH-1:0] press_pulse,
  output logic [N_CH-1:0] release_pulse
);

  logic [N_CH-1:0] deb_nx;
  logic [N_CH-1:0] rise;
  logic [N_CH-1:0] fall;

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    tgl_state_t st;
    tgl_state_t st_nx;
    logic latch_nx;
    logic so_q;
    logic pp_q;
    logic rp_q;

    button_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .CNT_W(CNT_W)
    ) u_deb (
      .clk(clk),
      .rst_n(rst_n),
      .button(button[i]),
      .deb_next(deb_nx[i]),
      .accept_rise(rise[i]),
      .accept_fall(fall[i])
    );

    always_comb begin
      st_nx = st;
      if (clear) begin
        st_nx = deb_nx[i] ? OFF_HELD : OFF_IDLE;
      end else begin
        unique case (1'b1)
          rise[i] && st == OFF_IDLE: st_nx = ON_HELD;
          fall[i] && st == ON_HELD:  st_nx = ON_IDLE;
          rise[i] && st == ON_IDLE:  st_nx = OFF_HELD;
          fall[i] && st == OFF_HELD: st_nx = OFF_IDLE;
          default: ;
        endcase
      end
      latch_nx = (st_nx == ON_HELD) || (st_nx == ON_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        st   <= OFF_IDLE;
        so_q <= 1'b0;
        pp_q <= 1'b0;
        rp_q <= 1'b0;
      end else begin
        st   <= st_nx;
        so_q <= (mode[i] == MODE_MOMENTARY) ? deb_nx[i] : latch_nx;
        pp_q <= rise[i];
        rp_q <= fall[i];
      end
    end

    assign state_out[i]     = so_q;
    assign press_pulse[i]   = pp_q;
    assign release_pulse[i] = rp_q;
  end

endmodule
